// File: rtl/cv32e40p_fetch_fifo_nmr.sv
// Fault-tolerant instruction fetch FIFO. It keeps REPLICAS independent copies
// of storage, pointers and count, and every output is a bitwise majority vote
// over the copies. A copy that disagrees with the vote is flagged and then
// reloaded from the voted state on the following edge. Per-copy saturating
// error counters raise a sticky broken flag.
//
// Handshake: a push happens on an edge where in_valid_i & in_ready_o & ~flush_i,
// and a pop happens on an edge where out_valid_o & out_ready_i & ~flush_i.
// in_ready_o and out_valid_o depend only on registered state, never on the
// same-cycle valid/ready inputs. A pushed entry becomes visible the cycle after
// its push edge, so there is no fall-through path.
module cv32e40p_fetch_fifo_nmr #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REPLICAS   = 3,
  parameter int unsigned ERR_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_W-1:0]        in_rdata_i,
  input  logic [ADDR_W-1:0]        in_addr_i,
  input  logic                     in_err_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_rdata_o,
  output logic [ADDR_W-1:0]        out_addr_o,
  output logic                     out_err_o,
  output logic [$clog2(DEPTH):0]   count_o,
  input  logic [REPLICAS-1:0]      inj_i,
  input  logic [REPLICAS-1:0]      set_broken_i,
  output logic [REPLICAS-1:0]      err_detected_o,
  output logic [REPLICAS-1:0]      err_corrected_o,
  output logic [REPLICAS-1:0]      is_broken_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 1 + ADDR_W + DATA_W;    // {err, addr, rdata}
  localparam int unsigned TW = 2 * PW + CW + EW;       // {wptr, rptr, count, head}

  logic [PW-1:0] wptr_q [REPLICAS];
  logic [PW-1:0] rptr_q [REPLICAS];
  logic [CW-1:0] cnt_q  [REPLICAS];
  logic [EW-1:0] mem_q  [REPLICAS][DEPTH];
  logic [EW-1:0] mem_d  [REPLICAS][DEPTH];
  logic [3:0]    ecnt_q [REPLICAS];
  logic [3:0]    ecnt_d [REPLICAS];
  logic [REPLICAS-1:0] broken_q;
  logic [REPLICAS-1:0] corr_q;
  logic [REPLICAS-1:0] det;

  logic [TW-1:0] tup [REPLICAS];
  logic [TW-1:0] v_tup;
  logic [PW-1:0] v_wptr, v_rptr;
  logic [CW-1:0] v_cnt;
  logic [EW-1:0] v_head;
  logic          push, pop;
  logic [PW-1:0] n_wptr, n_rptr;
  logic [CW-1:0] n_cnt;
  logic [EW-1:0] push_entry;

  // Each copy's state tuple; the head entry is read at that copy's own rptr.
  always_comb begin
    for (int r = 0; r < REPLICAS; r++) begin
      tup[r] = {wptr_q[r], rptr_q[r], cnt_q[r], mem_q[r][rptr_q[r]]};
    end
  end

  generate
    if (REPLICAS == 3) begin : g_tmr
      assign v_tup = (tup[0] & tup[1]) | (tup[0] & tup[2]) | (tup[1] & tup[2]);
      // A copy is faulty whenever any bit of its tuple differs from the vote.
      always_comb begin
        det = '0;
        for (int r = 0; r < 3; r++) begin
          det[r] = (tup[r] != v_tup);
        end
      end
    end else begin : g_single
      assign v_tup = tup[0];
      assign det   = '0;
    end
  endgenerate

  assign {v_wptr, v_rptr, v_cnt, v_head} = v_tup;

  assign in_ready_o  = (v_cnt < CW'(DEPTH));
  assign out_valid_o = (v_cnt != '0);
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;
  assign push_entry  = {in_err_i, in_addr_i, in_rdata_i};

  // Next pointers/count are derived from the voted state, so every copy,
  // faulty or not, converges on the voted value at each edge.
  always_comb begin
    n_wptr = v_wptr + PW'(push);
    n_rptr = v_rptr + PW'(pop);
    n_cnt  = v_cnt + CW'(push) - CW'(pop);
    if (flush_i) begin
      n_wptr = '0;
      n_rptr = '0;
      n_cnt  = '0;
    end
  end

  // Storage update per copy: repair the voted head slot, then the push write,
  // then the injected flip of rdata bit 0 at the copy's own head slot.
  always_comb begin
    for (int r = 0; r < REPLICAS; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[r][i] = mem_q[r][i];
        if (det[r] && (PW'(i) == v_rptr)) mem_d[r][i] = v_head;
        if (push && (PW'(i) == v_wptr))   mem_d[r][i] = push_entry;
        if (inj_i[r] && (PW'(i) == rptr_q[r])) mem_d[r][i][0] = ~mem_d[r][i][0];
      end
    end
  end

  // Saturating per-copy count of detected disagreements.
  always_comb begin
    for (int r = 0; r < REPLICAS; r++) begin
      ecnt_d[r] = ecnt_q[r];
      if (det[r] && (ecnt_q[r] < 4'(ERR_THRESH))) ecnt_d[r] = ecnt_q[r] + 4'd1;
    end
  end

  // State registers for all copies plus the error bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REPLICAS; r++) begin
        wptr_q[r] <= '0;
        rptr_q[r] <= '0;
        cnt_q[r]  <= '0;
        ecnt_q[r] <= '0;
        for (int i = 0; i < DEPTH; i++) mem_q[r][i] <= '0;
      end
      broken_q <= '0;
      corr_q   <= '0;
    end else begin
      for (int r = 0; r < REPLICAS; r++) begin
        wptr_q[r]   <= n_wptr;
        rptr_q[r]   <= n_rptr;
        cnt_q[r]    <= n_cnt;
        ecnt_q[r]   <= ecnt_d[r];
        broken_q[r] <= broken_q[r] | set_broken_i[r] | (ecnt_d[r] == 4'(ERR_THRESH));
        for (int i = 0; i < DEPTH; i++) mem_q[r][i] <= mem_d[r][i];
      end
      corr_q <= det;
    end
  end

  assign out_err_o       = v_head[EW-1];
  assign out_addr_o      = v_head[DATA_W +: ADDR_W];
  assign out_rdata_o     = v_head[DATA_W-1:0];
  assign count_o         = v_cnt;
  assign err_detected_o  = det;
  assign err_corrected_o = corr_q;
  assign is_broken_o     = broken_q;

endmodule

// File: tb/tb_cv32e40p_fetch_fifo_nmr.sv
// Bench for the fault-tolerant fetch FIFO: directed vector table, hand-written
// injection/broken sequences, and random traffic against a queue model.
module tb_cv32e40p_fetch_fifo_nmr;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_rdata_i;
  logic [31:0] in_addr_i;
  logic        in_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_err_o;
  logic [2:0]  count_o;
  logic [2:0]  inj_i;
  logic [2:0]  set_broken_i;
  logic [2:0]  err_detected_o;
  logic [2:0]  err_corrected_o;
  logic [2:0]  is_broken_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the FIFO contents in order, head at index 0.
  logic [64:0] exp_q[$];

  cv32e40p_fetch_fifo_nmr dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_rdata_i(in_rdata_i), .in_addr_i(in_addr_i), .in_err_i(in_err_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_rdata_o(out_rdata_o), .out_addr_o(out_addr_o), .out_err_o(out_err_o),
    .count_o(count_o), .inj_i(inj_i), .set_broken_i(set_broken_i),
    .err_detected_o(err_detected_o), .err_corrected_o(err_corrected_o),
    .is_broken_o(is_broken_o)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush_i = 0; in_valid_i = 0; out_ready_i = 0;
    in_rdata_i = 0; in_addr_i = 0; in_err_i = 0;
    inj_i = 0; set_broken_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    exp_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 72'(count_o), 72'd0);
    check({tag, "_valid"}, 72'(out_valid_o), 72'd0);
    check({tag, "_ready"}, 72'(in_ready_o), 72'd1);
    check({tag, "_head"}, 72'({out_err_o, out_addr_o, out_rdata_o}), 72'd0);
    check({tag, "_flags"}, 72'({err_detected_o, err_corrected_o, is_broken_o}), 72'd0);
  endtask

  // One cycle of traffic checked against the queue model before the edge.
  task automatic model_cycle(input logic v, input logic r, input logic f,
                             input logic [31:0] d, input logic [31:0] a, input logic e);
    logic exp_ready, exp_valid, do_push, do_pop;
    exp_ready = (exp_q.size() < 4);
    exp_valid = (exp_q.size() != 0);
    flush_i = f; in_valid_i = v; out_ready_i = r;
    in_rdata_i = d; in_addr_i = a; in_err_i = e;
    check("m_count", 72'(count_o), 72'(exp_q.size()));
    check("m_in_ready", 72'(in_ready_o), 72'(exp_ready));
    check("m_out_valid", 72'(out_valid_o), 72'(exp_valid));
    if (exp_valid) check("m_head", 72'({out_err_o, out_addr_o, out_rdata_o}), 72'(exp_q[0]));
    check("m_detected", 72'(err_detected_o), 72'd0);
    do_push = v & exp_ready & ~f;
    do_pop  = exp_valid & r & ~f;
    step();
    if (f) exp_q.delete();
    else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({e, a, d});
    end
  endtask

  typedef struct {
    logic        valid, ready, flush;
    logic [31:0] rdata, addr;
    logic        e_valid, e_iready;
    logic [2:0]  e_count;
    logic        chk_head;
    logic [31:0] e_rdata, e_addr;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int max_cnt;
    int n_pop;

    // Directed vectors: fill, full push+pop, drain, flush, push after flush.
    tbl[0]  = '{1, 0, 0, 32'h00000013, 32'h80, 1, 1, 3'd1, 1, 32'h00000013, 32'h80};
    tbl[1]  = '{1, 0, 0, 32'h00100093, 32'h84, 1, 1, 3'd2, 1, 32'h00000013, 32'h80};
    tbl[2]  = '{1, 0, 0, 32'h00200113, 32'h88, 1, 1, 3'd3, 1, 32'h00000013, 32'h80};
    tbl[3]  = '{1, 0, 0, 32'h00300193, 32'h8C, 1, 0, 3'd4, 1, 32'h00000013, 32'h80};
    tbl[4]  = '{1, 1, 0, 32'hDEAD0000, 32'hF0, 1, 1, 3'd3, 1, 32'h00100093, 32'h84};
    tbl[5]  = '{0, 1, 0, 32'h0,        32'h0,  1, 1, 3'd2, 1, 32'h00200113, 32'h88};
    tbl[6]  = '{0, 1, 0, 32'h0,        32'h0,  1, 1, 3'd1, 1, 32'h00300193, 32'h8C};
    tbl[7]  = '{0, 1, 0, 32'h0,        32'h0,  0, 1, 3'd0, 0, 32'h0,        32'h0};
    tbl[8]  = '{1, 0, 0, 32'h00500293, 32'hA0, 1, 1, 3'd1, 1, 32'h00500293, 32'hA0};
    tbl[9]  = '{1, 0, 0, 32'h00600313, 32'hA4, 1, 1, 3'd2, 1, 32'h00500293, 32'hA0};
    tbl[10] = '{1, 0, 0, 32'h00700393, 32'hA8, 1, 1, 3'd3, 1, 32'h00500293, 32'hA0};
    tbl[11] = '{1, 1, 1, 32'hDEAD0001, 32'hAC, 0, 1, 3'd0, 0, 32'h0,        32'h0};
    tbl[12] = '{1, 0, 0, 32'h00800413, 32'hB0, 1, 1, 3'd1, 1, 32'h00800413, 32'hB0};
    tbl[13] = '{0, 1, 0, 32'h0,        32'h0,  0, 1, 3'd0, 0, 32'h0,        32'h0};

    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    check_reset_state("reset");

    for (int i = 0; i < 14; i++) begin
      in_valid_i = tbl[i].valid; out_ready_i = tbl[i].ready; flush_i = tbl[i].flush;
      in_rdata_i = tbl[i].rdata; in_addr_i = tbl[i].addr; in_err_i = 0;
      step();
      check($sformatf("vec%0d_count", i), 72'(count_o), 72'(tbl[i].e_count));
      check($sformatf("vec%0d_valid", i), 72'(out_valid_o), 72'(tbl[i].e_valid));
      check($sformatf("vec%0d_in_ready", i), 72'(in_ready_o), 72'(tbl[i].e_iready));
      if (tbl[i].chk_head) begin
        check($sformatf("vec%0d_rdata", i), 72'(out_rdata_o), 72'(tbl[i].e_rdata));
        check($sformatf("vec%0d_addr", i), 72'(out_addr_o), 72'(tbl[i].e_addr));
      end
      check($sformatf("vec%0d_detected", i), 72'(err_detected_o), 72'd0);
    end
    idle_inputs();

    // Wrap/order: 6 pushes, popping every cycle from cycle 2.
    do_reset();
    max_cnt = 0;
    n_pop = 0;
    for (int c = 0; c < 10; c++) begin
      if (exp_q.size() != 0 && c >= 2) n_pop++;
      model_cycle(c < 6, c >= 2, 1'b0, 32'h1000 + 32'(c), 32'h200 + 32'(4 * c), 1'b0);
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
    end
    check("wrap_max_count", 72'(max_cnt), 72'd2);
    check("wrap_pops", 72'(n_pop), 72'd6);
    check("wrap_empty", 72'(out_valid_o), 72'd0);
    idle_inputs();

    // Correction of a single injected fault on replica 1.
    do_reset();
    in_valid_i = 1; in_rdata_i = 32'hDEADBEEF; in_addr_i = 32'hC0;
    step();
    idle_inputs();
    inj_i = 3'b010;
    step();
    inj_i = 3'b000;
    check("inj_detected", 72'(err_detected_o), 72'b010);
    check("inj_rdata_t1", 72'(out_rdata_o), 72'hDEADBEEF);
    check("inj_corrected_t1", 72'(err_corrected_o), 72'd0);
    step();
    check("inj_corrected", 72'(err_corrected_o), 72'b010);
    check("inj_detected_clear", 72'(err_detected_o), 72'd0);
    check("inj_rdata_t2", 72'(out_rdata_o), 72'hDEADBEEF);
    check("inj_count", 72'(count_o), 72'd1);
    step();
    check("inj_corrected_clear", 72'(err_corrected_o), 72'd0);

    // Broken threshold on replica 2 (empty FIFO, head still compared).
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      inj_i = 3'b100;
      step();
      inj_i = 3'b000;
      check($sformatf("brk%0d_detected", k), 72'(err_detected_o), 72'b100);
      step();
      check($sformatf("brk%0d_broken", k), 72'(is_broken_o), (k < 4) ? 72'd0 : 72'b100);
    end
    check("brk_count", 72'(count_o), 72'd0);
    flush_i = 1;
    step();
    flush_i = 0;
    check("brk_after_flush", 72'(is_broken_o), 72'b100);
    set_broken_i = 3'b001;
    step();
    set_broken_i = 3'b000;
    check("brk_set_broken", 72'(is_broken_o), 72'b101);
    rst = 1; inj_i = 3'b111; set_broken_i = 3'b111; in_valid_i = 1;
    step();
    idle_inputs();
    rst = 0;
    check_reset_state("rst_override");

    // Random traffic against the queue model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      model_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0, $urandom, $urandom,
                  $urandom_range(0, 7) == 0);
    end
    check("rand_final_count", 72'(count_o), 72'(exp_q.size()));
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
